// File: rtl/sevenseg_4digit_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sevenseg_4digit_capture_if
// Brief    : Cathode/anode bus plus captured-digit outputs of the capture block.
// Revision : 1.0  initial release
// ============================================================================
interface sevenseg_4digit_capture_if;
    logic [6:0] cathode;
    logic [3:0] an;
    logic [6:0] digit0;
    logic [6:0] digit1;
    logic [6:0] digit2;
    logic [6:0] digit3;
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex3;
    logic [3:0] valid;
    logic       frame_done;
    logic       an_error;

    // master: display driver / stimulus side; slave: capture block
    modport master (
        output cathode, an,
        input  digit0, digit1, digit2, digit3,
        input  hex0, hex1, hex2, hex3, valid, frame_done, an_error
    );
    modport slave (
        input  cathode, an,
        output digit0, digit1, digit2, digit3,
        output hex0, hex1, hex2, hex3, valid, frame_done, an_error
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_4digit_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sevenseg_4digit_capture
// Brief    : Captures multiplexed 7-segment digits after a stable window,
//            decodes them to hex, tracks staleness and frame completion.
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_4digit_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT_W     = 20
) (
    input  wire logic               clk,
    input  wire logic               reset,
    sevenseg_4digit_capture_if.slave bus
);
    localparam int                   c_CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_CAP = c_CNT_W'(STABLE_CYCLES - 2);
    localparam logic [10:0]          c_IDLE    = {4'hF, 7'h7F};
    localparam logic [TIMEOUT_W-1:0] c_AGE_MAX = '1;

    // {legal, nibble} for an active-low {g..a} pattern
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'h40: f_decode = 5'h10;  7'h79: f_decode = 5'h11;
            7'h24: f_decode = 5'h12;  7'h30: f_decode = 5'h13;
            7'h19: f_decode = 5'h14;  7'h12: f_decode = 5'h15;
            7'h02: f_decode = 5'h16;  7'h78: f_decode = 5'h17;
            7'h00: f_decode = 5'h18;  7'h10: f_decode = 5'h19;
            7'h08: f_decode = 5'h1A;  7'h03: f_decode = 5'h1B;
            7'h46: f_decode = 5'h1C;  7'h21: f_decode = 5'h1D;
            7'h06: f_decode = 5'h1E;  7'h0E: f_decode = 5'h1F;
            default: f_decode = 5'h00;
        endcase
    endfunction

    logic [10:0]          r_s1_q, r_s2_q, w_s1_d, w_s2_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [6:0]           r_digit_q [4];
    logic [6:0]           w_digit_d [4];
    logic [TIMEOUT_W-1:0] r_age_q [4];
    logic [TIMEOUT_W-1:0] w_age_d [4];
    logic [3:0]           r_mask_q, w_mask_d;
    logic                 r_frame_done_q, w_frame_done_d;
    logic                 r_an_error_q, w_an_error_d;

    logic       w_changed, w_an_legal, w_an_illegal, w_capture;
    logic [3:0] w_an, w_sel, w_mask_set;
    logic [6:0] w_cat;
    logic [4:0] w_dec [4];

    always_comb begin
        w_s1_d       = {bus.an, bus.cathode};
        w_s2_d       = r_s1_q;
        w_an         = r_s1_q[10:7];
        w_cat        = r_s1_q[6:0];
        w_sel        = ~w_an;
        w_changed    = (r_s1_q != r_s2_q);
        w_an_legal   = (w_an == 4'b1110) || (w_an == 4'b1101) ||
                       (w_an == 4'b1011) || (w_an == 4'b0111);
        w_an_illegal = !w_an_legal && (w_an != 4'b1111);

        if (w_changed)
            w_cnt_d = '0;
        else if (r_cnt_q < c_CNT_MAX)
            w_cnt_d = r_cnt_q + 1'b1;
        else
            w_cnt_d = r_cnt_q;

        // saturation at CNT_MAX means CNT_CAP is passed once per stable interval
        w_capture = !w_changed && (r_cnt_q == c_CNT_CAP) && w_an_legal;

        for (int i = 0; i < 4; i++) begin
            if (w_capture && w_sel[i]) begin
                w_digit_d[i] = w_cat;
                w_age_d[i]   = '0;
            end else begin
                w_digit_d[i] = r_digit_q[i];
                w_age_d[i]   = (r_age_q[i] == c_AGE_MAX) ? c_AGE_MAX
                                                         : r_age_q[i] + 1'b1;
            end
        end

        w_mask_set     = r_mask_q | (w_capture ? w_sel : 4'b0000);
        w_frame_done_d = 1'b0;
        w_mask_d       = w_mask_set;
        if (w_capture && (w_mask_set == 4'b1111)) begin
            w_frame_done_d = 1'b1;
            w_mask_d       = 4'b0000;
        end

        w_an_error_d = w_changed && w_an_illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_q         <= c_IDLE;
            r_s2_q         <= c_IDLE;
            r_cnt_q        <= '0;
            r_mask_q       <= 4'b0000;
            r_frame_done_q <= 1'b0;
            r_an_error_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_digit_q[i] <= 7'h7F;
                r_age_q[i]   <= '0;
            end
        end else begin
            r_s1_q         <= w_s1_d;
            r_s2_q         <= w_s2_d;
            r_cnt_q        <= w_cnt_d;
            r_mask_q       <= w_mask_d;
            r_frame_done_q <= w_frame_done_d;
            r_an_error_q   <= w_an_error_d;
            for (int i = 0; i < 4; i++) begin
                r_digit_q[i] <= w_digit_d[i];
                r_age_q[i]   <= w_age_d[i];
            end
        end
    end

    logic [3:0] w_valid;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_decode
            assign w_dec[g]   = f_decode(r_digit_q[g]);
            assign w_valid[g] = w_dec[g][4] && (r_age_q[g] != c_AGE_MAX);
        end
    endgenerate

    assign bus.digit0     = r_digit_q[0];
    assign bus.digit1     = r_digit_q[1];
    assign bus.digit2     = r_digit_q[2];
    assign bus.digit3     = r_digit_q[3];
    assign bus.hex0       = w_dec[0][3:0];
    assign bus.hex1       = w_dec[1][3:0];
    assign bus.hex2       = w_dec[2][3:0];
    assign bus.hex3       = w_dec[3][3:0];
    assign bus.valid      = w_valid;
    assign bus.frame_done = r_frame_done_q;
    assign bus.an_error   = r_an_error_q;
endmodule
`default_nettype wire

// File: tb/tb_sevenseg_4digit_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_4digit_capture
// Brief    : Directed bench for sevenseg_4digit_capture (STABLE_CYCLES=4, TIMEOUT_W=6).
// Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_4digit_capture;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   fd_pulses = 0;
    int   err_pulses = 0;
    int   fd0, err0;

    sevenseg_4digit_capture_if bus ();

    sevenseg_4digit_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_W     (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.frame_done === 1'b1) fd_pulses++;
        if (bus.an_error === 1'b1)   err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
        bus.an      = a;
        bus.cathode = c;
        ticks(n);
    endtask

    function automatic logic [27:0] digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    function automatic logic [15:0] hexes();
        return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    // digits 0..2 held 6 samples each; digit3 checked around its capture edge
    task automatic drive_frame(input logic [6:0] c0, input logic [6:0] c1,
                               input logic [6:0] c2, input logic [6:0] c3);
        hold(4'b1110, c0, 6);
        hold(4'b1101, c1, 6);
        hold(4'b1011, c2, 6);
        hold(4'b0111, c3, 4);
        chk("fd_before_d3", {31'd0, bus.frame_done}, 32'd0);
        ticks(1);
        chk("fd_at_d3", {31'd0, bus.frame_done}, 32'd1);
        chk("d3_capture", {25'd0, bus.digit3}, {25'd0, c3});
        ticks(1);
        chk("fd_after_d3", {31'd0, bus.frame_done}, 32'd0);
    endtask

    initial begin
        logic [27:0] exp_dig;
        bus.an      = 4'b1111;
        bus.cathode = 7'h7F;

        // reset
        ticks(2);
        chk("rst_digits", {4'd0, digits()}, {4'd0, 28'hFFFFFFF});
        chk("rst_hex",    {16'd0, hexes()}, 32'd0);
        chk("rst_valid",  {28'd0, bus.valid}, 32'd0);
        chk("rst_fd",     {31'd0, bus.frame_done}, 32'd0);
        chk("rst_anerr",  {31'd0, bus.an_error}, 32'd0);
        reset = 1'b0;

        // three samples only: no capture
        hold(4'b1110, 7'h24, 3);
        hold(4'b1111, 7'h7F, 6);
        chk("short_hold_d0", {25'd0, bus.digit0}, 32'h7F);

        // four samples: capture lands on edge 4
        hold(4'b1110, 7'h24, 4);
        chk("d0_before_edge4", {25'd0, bus.digit0}, 32'h7F);
        hold(4'b1111, 7'h7F, 1);
        chk("d0_at_edge4",  {25'd0, bus.digit0}, 32'h24);
        chk("hex0_at_edge4", {28'd0, bus.hex0}, 32'h2);
        chk("valid_at_edge4", {28'd0, bus.valid}, 32'b0001);
        ticks(4);

        // full frame
        fd0 = fd_pulses;
        drive_frame(7'h79, 7'h30, 7'h12, 7'h0E);
        ticks(2);
        chk("frame1_pulses", fd_pulses, fd0 + 1);
        chk("frame1_hex",    {16'd0, hexes()}, 32'hF531);
        chk("frame1_valid",  {28'd0, bus.valid}, 32'b1111);

        // second frame
        fd0 = fd_pulses;
        drive_frame(7'h40, 7'h24, 7'h19, 7'h78);
        ticks(2);
        chk("frame2_pulses", fd_pulses, fd0 + 1);
        chk("frame2_hex",    {16'd0, hexes()}, 32'h7420);
        chk("frame2_valid",  {28'd0, bus.valid}, 32'b1111);

        // illegal anode held: single pulse, no capture
        err0    = err_pulses;
        fd0     = fd_pulses;
        exp_dig = {7'h78, 7'h19, 7'h24, 7'h40};
        hold(4'b1100, 7'h40, 10);
        chk("illegal_pulses", err_pulses, err0 + 1);
        chk("illegal_nocap",  {4'd0, digits()}, {4'd0, exp_dig});
        hold(4'b1111, 7'h7F, 6);
        chk("blank_no_err",   err_pulses, err0 + 1);
        chk("illegal_no_fd",  fd_pulses, fd0);

        // blank glyph captured on digit1
        hold(4'b1101, 7'h7F, 6);
        chk("glyph_d1",    {25'd0, bus.digit1}, 32'h7F);
        chk("glyph_hex1",  {28'd0, bus.hex1}, 32'h0);
        chk("glyph_valid", {28'd0, bus.valid}, 32'b1101);

        // staleness: capture 00 on digit2, valid drops 63 edges later
        hold(4'b1011, 7'h00, 4);
        hold(4'b1111, 7'h7F, 1);
        chk("stale_cap_hex2",  {28'd0, bus.hex2}, 32'h8);
        chk("stale_cap_valid", {31'd0, bus.valid[2]}, 32'd1);
        ticks(62);
        chk("stale_62_valid",  {31'd0, bus.valid[2]}, 32'd1);
        ticks(1);
        chk("stale_63_valid",  {31'd0, bus.valid[2]}, 32'd0);
        chk("stale_63_digit2", {25'd0, bus.digit2}, 32'h00);

        // reset mid-frame discards partial frame
        hold(4'b1110, 7'h79, 6);
        hold(4'b1101, 7'h24, 6);
        bus.an      = 4'b1111;
        bus.cathode = 7'h7F;
        reset       = 1'b1;
        ticks(1);
        reset       = 1'b0;
        chk("midrst_digits", {4'd0, digits()}, {4'd0, 28'hFFFFFFF});
        fd0 = fd_pulses;
        hold(4'b1011, 7'h30, 6);
        hold(4'b0111, 7'h19, 6);
        hold(4'b1111, 7'h7F, 4);
        chk("midrst_no_fd", fd_pulses, fd0);
        chk("midrst_d3",    {25'd0, bus.digit3}, 32'h19);
        hold(4'b1110, 7'h12, 6);
        chk("midrst_d0_no_fd", fd_pulses, fd0);
        hold(4'b1101, 7'h02, 6);
        chk("midrst_fd", fd_pulses, fd0 + 1);
        chk("midrst_hex", {16'd0, hexes()}, 32'h4365);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
